// File: rtl/pipe_stage_ctrl.sv
// pipe_stage_ctrl: PC and F/D, D/E, E/M, M/W pipeline registers driven by hazard-unit Stall and D-stage redirect.
// Optional performance counters are built when PERF_CNT_EN is defined.
module pipe_stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_IR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        D_redirect,
    input  logic [31:0] D_npc,
    input  logic [31:0] F_instr,
    output logic [31:0] F_PC,
    output logic [31:0] D_IR,
    output logic [31:0] D_PC,
    output logic [31:0] E_IR,
    output logic [31:0] E_PC,
    output logic [31:0] M_IR,
    output logic [31:0] M_PC,
    output logic [31:0] W_IR,
    output logic [31:0] W_PC,
    output logic        W_valid,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_retire,
    output logic [31:0] perf_stall
);
    // Index 0..3 = F/D, D/E, E/M, M/W
    logic [31:0]       pc_q, pc_d;
    logic [3:0][31:0]  ir_q, ir_d, spc_q, spc_d;
    logic [3:0]        v_q, v_d;

    always_comb begin
        pc_d     = Stall ? pc_q : (D_redirect ? D_npc : pc_q + 32'd4);
        ir_d[0]  = Stall ? ir_q[0]  : F_instr;
        spc_d[0] = Stall ? spc_q[0] : pc_q;
        v_d[0]   = Stall ? v_q[0]   : 1'b1;
        ir_d[1]  = Stall ? NOP_IR   : ir_q[0];
        spc_d[1] = Stall ? 32'd0    : spc_q[0];
        v_d[1]   = Stall ? 1'b0     : v_q[0];
        ir_d[3:2]  = ir_q[2:1];
        spc_d[3:2] = spc_q[2:1];
        v_d[3:2]   = v_q[2:1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= {4{NOP_IR}};
            spc_q <= '0;
            v_q   <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            spc_q <= spc_d;
            v_q   <= v_d;
        end
    end

    assign F_PC    = pc_q;
    assign D_IR    = ir_q[0];
    assign D_PC    = spc_q[0];
    assign E_IR    = ir_q[1];
    assign E_PC    = spc_q[1];
    assign M_IR    = ir_q[2];
    assign M_PC    = spc_q[2];
    assign W_IR    = ir_q[3];
    assign W_PC    = spc_q[3];
    assign W_valid = v_q[3];

`ifdef PERF_CNT_EN
    logic [31:0] cyc_q, ret_q, stl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
            ret_q <= '0;
            stl_q <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            ret_q <= ret_q + {31'd0, v_q[3]};
            stl_q <= stl_q + {31'd0, Stall};
        end
    end

    assign perf_cycles = cyc_q;
    assign perf_retire = ret_q;
    assign perf_stall  = stl_q;
`else
    assign perf_cycles = '0;
    assign perf_retire = '0;
    assign perf_stall  = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// tb_pipe_stage_ctrl: directed and randomized checks of pipe_stage_ctrl against a stage-array reference model.
module tb_pipe_stage_ctrl;
    logic        clk = 1'b0, reset = 1'b1, Stall = 1'b0, D_redirect = 1'b0;
    logic [31:0] D_npc = '0, F_instr;
    logic [31:0] F_PC, D_IR, D_PC, E_IR, E_PC, M_IR, M_PC, W_IR, W_PC;
    logic [31:0] perf_cycles, perf_retire, perf_stall;
    logic        W_valid;
    int          n_chk = 0, n_fail = 0;
    bit          chk_on = 1'b0;

    pipe_stage_ctrl dut (
        .clk(clk), .reset(reset), .Stall(Stall), .D_redirect(D_redirect), .D_npc(D_npc),
        .F_instr(F_instr), .F_PC(F_PC), .D_IR(D_IR), .D_PC(D_PC), .E_IR(E_IR), .E_PC(E_PC),
        .M_IR(M_IR), .M_PC(M_PC), .W_IR(W_IR), .W_PC(W_PC), .W_valid(W_valid),
        .perf_cycles(perf_cycles), .perf_retire(perf_retire), .perf_stall(perf_stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    assign F_instr = imem(F_PC);

    // Reference model: stage k holds {ir, pc, valid}; 0 = F/D ... 3 = M/W
    logic [31:0] m_pc;
    logic [31:0] m_ir [4];
    logic [31:0] m_spc [4];
    bit          m_v [4];
    int unsigned m_cyc, m_ret, m_stl;

    task automatic m_reset();
        m_pc = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
            m_ir[i] = '0; m_spc[i] = '0; m_v[i] = 1'b0;
        end
        m_cyc = 0; m_ret = 0; m_stl = 0;
    endtask

    task automatic m_tick();
        m_cyc++;
        if (m_v[3]) m_ret++;
        if (Stall) m_stl++;
        for (int i = 3; i >= 2; i--) begin
            m_ir[i] = m_ir[i-1]; m_spc[i] = m_spc[i-1]; m_v[i] = m_v[i-1];
        end
        if (Stall) begin
            m_ir[1] = '0; m_spc[1] = '0; m_v[1] = 1'b0;
        end else begin
            m_ir[1] = m_ir[0]; m_spc[1] = m_spc[0]; m_v[1] = m_v[0];
            m_ir[0] = imem(m_pc); m_spc[0] = m_pc; m_v[0] = 1'b1;
            m_pc = D_redirect ? D_npc : m_pc + 32'd4;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("F_PC", F_PC, m_pc);
            chk("D_IR", D_IR, m_ir[0]);  chk("D_PC", D_PC, m_spc[0]);
            chk("E_IR", E_IR, m_ir[1]);  chk("E_PC", E_PC, m_spc[1]);
            chk("M_IR", M_IR, m_ir[2]);  chk("M_PC", M_PC, m_spc[2]);
            chk("W_IR", W_IR, m_ir[3]);  chk("W_PC", W_PC, m_spc[3]);
            chk("W_valid", {31'd0, W_valid}, {31'd0, m_v[3]});
`ifdef PERF_CNT_EN
            chk("perf_cycles", perf_cycles, m_cyc);
            chk("perf_retire", perf_retire, m_ret);
            chk("perf_stall", perf_stall, m_stl);
`else
            chk("perf_cycles", perf_cycles, 32'd0);
            chk("perf_retire", perf_retire, 32'd0);
            chk("perf_stall", perf_stall, 32'd0);
`endif
        end
    end

    // Inputs change at negedge; model advances with the DUT at posedge
    task automatic step(input bit s, input bit r, input logic [31:0] n);
        Stall = s; D_redirect = r; D_npc = n;
        @(posedge clk);
        m_tick();
        @(negedge clk);
    endtask

    // Reset lands mid-cycle and must act immediately
    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b1;
        m_reset();
        #1;
        chk("rst F_PC", F_PC, 32'h0000_3000);
        chk("rst D_IR", D_IR, 32'h0);
        chk("rst E_IR", E_IR, 32'h0);
        chk("rst M_IR", M_IR, 32'h0);
        chk("rst W_IR", W_IR, 32'h0);
        chk("rst W_valid", {31'd0, W_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        Stall = 1'b0; D_redirect = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        m_reset();
        chk_on = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
        // T1/T2: reset over live pipeline, then straight-line flow
        do_reset();
        step(1'b0, 1'b0, '0);
        chk("T2 D_PC c1", D_PC, 32'h0000_3000);
        chk("T2 D_IR c1", D_IR, imem(32'h0000_3000));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("T2 W_valid c3", {31'd0, W_valid}, 32'd0);
        step(1'b0, 1'b0, '0);
        chk("T2 W_PC c4", W_PC, 32'h0000_3000);
        chk("T2 W_valid c4", {31'd0, W_valid}, 32'd1);
        // T3: two stall cycles with D_PC=0x3004
        do_reset();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, '0);
            chk("T3 F_PC held", F_PC, 32'h0000_3008);
            chk("T3 D_PC held", D_PC, 32'h0000_3004);
            chk("T3 E_IR bubble", E_IR, 32'h0);
        end
        step(1'b0, 1'b0, '0);
        chk("T3 E_PC release", E_PC, 32'h0000_3004);
        // T4/T5: redirect with delay slot, then stall colliding with redirect
        do_reset();
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h0000_3100);
        chk("T4 delay slot D_PC", D_PC, 32'h0000_3008);
        chk("T4 F_PC target", F_PC, 32'h0000_3100);
        step(1'b1, 1'b1, 32'h0000_3200);
        chk("T5 F_PC held", F_PC, 32'h0000_3100);
        step(1'b0, 1'b1, 32'h0000_3200);
        chk("T5 F_PC target", F_PC, 32'h0000_3200);
        // T6: 10 cycles, stalls on cycles 3 and 4
        do_reset();
        for (int i = 1; i <= 10; i++) step(i == 3 || i == 4, 1'b0, '0);
`ifdef PERF_CNT_EN
        chk("T6 perf_cycles", perf_cycles, 32'd10);
        chk("T6 perf_stall", perf_stall, 32'd2);
        chk("T6 perf_retire", perf_retire, 32'd4);
`else
        chk("T6 perf_cycles off", perf_cycles, 32'd0);
        chk("T6 perf_stall off", perf_stall, 32'd0);
        chk("T6 perf_retire off", perf_retire, 32'd0);
`endif
        // Randomized traffic with occasional reset, including mid-stall
        for (int i = 0; i < 400; i++) begin
            if (i % 150 == 149) do_reset();
            step($urandom_range(3) == 0, $urandom_range(3) == 0, {$urandom(), 2'b00} >> 0);
        end
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
